// File: rtl/reset_pulse_sequencer_if.sv
// Handshake bundle between a reset requester and the pulse sequencer.
// RW must equal the sequencer's retry counter width, $clog2(MAX_RETRY+1).
interface reset_pulse_sequencer_if #(
  parameter int RW = 2
) ();
  logic          req;
  logic          ack;
  logic          rst_out;
  logic          busy;
  logic          done;
  logic          fail;
  logic [RW-1:0] retry_cnt;

  modport master (
    output req, ack,
    input  rst_out, busy, done, fail, retry_cnt
  );

  modport slave (
    input  req, ack,
    output rst_out, busy, done, fail, retry_cnt
  );
endinterface

// File: rtl/reset_pulse_sequencer.sv
// Reset pulse sequencer: drives a fixed-length reset pulse toward the
// crossing FIFO write side, waits for the far-end acknowledge, retries on
// timeout and enforces a quiet holdoff after every sequence.
module reset_pulse_sequencer #(
  parameter int PULSE_LEN   = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int MAX_RETRY   = 3,
  parameter int HOLDOFF     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  reset_pulse_sequencer_if.slave  bus
);
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int M1      = (PULSE_LEN > ACK_TIMEOUT) ? PULSE_LEN : ACK_TIMEOUT;
  localparam int CNT_MAX = (M1 > HOLDOFF) ? M1 : HOLDOFF;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF - 1);
  localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_e;

  state_e        state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [RW-1:0] retry_q,   retry_d;
  logic          pending_q, pending_d;
  logic          fail_q,    fail_d;
  logic          done_q,    done_d;
  logic          rst_out_q, rst_out_d;
  logic          busy_q,    busy_d;
  logic          start;

  // Next-state logic; every sequence start (from IDLE or straight out of
  // HOLDOFF) funnels through 'start' so the clearing rules live in one place.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
    retry_d   = retry_q;
    pending_d = pending_q | (bus.req & (state_q != S_IDLE));
    fail_d    = fail_q;
    done_d    = 1'b0;
    start     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req || pending_q) start = 1'b1;
      end
      S_ASSERT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_WAIT_ACK;
          cnt_d   = '0;
        end
      end
      S_WAIT_ACK: begin
        // ack is checked before the timeout so a last-cycle ack still wins
        if (bus.ack) begin
          state_d = S_HOLDOFF;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (cnt_q == ACK_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_ASSERT;
          end else begin
            fail_d  = 1'b1;
            state_d = S_HOLDOFF;
          end
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (pending_q || bus.req) start = 1'b1;
          else                      state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d   = S_ASSERT;
      cnt_d     = '0;
      pending_d = 1'b0;
      retry_d   = '0;
      fail_d    = 1'b0;
    end
    rst_out_d = (state_d == S_ASSERT);
    busy_d    = (state_d != S_IDLE);
  end

  // State, counters and registered outputs; reset aborts silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      pending_q <= 1'b0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
      rst_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pending_q <= pending_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rst_out   = rst_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
endmodule

// File: tb/tb_reset_pulse_sequencer.sv
// Scoreboard bench: each scenario pushes the output edges it expects
// (kind, cycle, fail, retry_cnt); an independent monitor pops one entry for
// every edge it sees on busy/fail/rst_out/done and compares.
module tb_reset_pulse_sequencer;
  localparam int PL = 4, AT = 64, MR = 3, HO = 16, RW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reset_pulse_sequencer_if #(.RW(RW)) bus ();

  reset_pulse_sequencer #(
    .PULSE_LEN(PL), .ACK_TIMEOUT(AT), .MAX_RETRY(MR), .HOLDOFF(HO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum int {
    EV_BUSY_R = 0, EV_FAIL_F = 1, EV_FAIL_R = 2, EV_RST_R = 3,
    EV_RST_F = 4, EV_DONE_R = 5, EV_DONE_F = 6, EV_BUSY_F = 7
  } ev_e;

  typedef struct {
    ev_e  kind;
    int   cyc;
    logic fail;
    int   retry;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic expect_ev(input ev_e k, input int c, input logic f, input int r);
    ev_t e;
    e.kind = k; e.cyc = c; e.fail = f; e.retry = r;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input ev_e k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected none", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.fail !== bus.fail || e.retry != int'(bus.retry_cnt)) begin
        errors++;
        $display("FAIL event: got %s cyc=%0d fail=%0b retry=%0d expected %s cyc=%0d fail=%0b retry=%0d",
                 k.name(), cyc, bus.fail, bus.retry_cnt, e.kind.name(), e.cyc, e.fail, e.retry);
      end
    end
  endtask

  // Monitor: detect edges on the falling clock, in a fixed kind order.
  initial begin
    logic p_busy, p_fail, p_rst, p_done;
    bit   hit [8];
    p_busy = 1'b0; p_fail = 1'b0; p_rst = 1'b0; p_done = 1'b0;
    forever begin
      @(negedge clk);
      hit[0] = bus.busy    && !p_busy;
      hit[1] = !bus.fail   &&  p_fail;
      hit[2] = bus.fail    && !p_fail;
      hit[3] = bus.rst_out && !p_rst;
      hit[4] = !bus.rst_out && p_rst;
      hit[5] = bus.done    && !p_done;
      hit[6] = !bus.done   &&  p_done;
      hit[7] = !bus.busy   &&  p_busy;
      for (int k = 0; k < 8; k++)
        if (hit[k]) check_ev(ev_e'(k));
      p_busy = bus.busy; p_fail = bus.fail; p_rst = bus.rst_out; p_done = bus.done;
    end
  end

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Drive req/ack for 'len' cycles starting at the current falling edge;
  // step k is sampled by the DUT at the rising edge of cycle (start + k + 1).
  task automatic drive(input int reqs[$], input int acks[$], input bit ack_all, input int len);
    for (int k = 0; k < len; k++) begin
      bus.req = in_q(reqs, k);
      bus.ack = ack_all | in_q(acks, k);
      @(negedge clk);
    end
    bus.req = 1'b0;
    bus.ack = 1'b0;
  endtask

  initial begin
    int r;
    bus.req = 1'b0;
    bus.ack = 1'b0;
    #1;
    chk("reset_rst_out", int'(bus.rst_out), 0);
    chk("reset_busy",    int'(bus.busy), 0);
    chk("reset_done",    int'(bus.done), 0);
    chk("reset_fail",    int'(bus.fail), 0);
    chk("reset_retry",   int'(bus.retry_cnt), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, ack six cycles into the pulse window.
    r = cyc + 1;
    expect_ev(EV_BUSY_R, r, 0, 0);
    expect_ev(EV_RST_R,  r, 0, 0);
    expect_ev(EV_RST_F,  r + 4, 0, 0);
    expect_ev(EV_DONE_R, r + 7, 0, 0);
    expect_ev(EV_DONE_F, r + 8, 0, 0);
    expect_ev(EV_BUSY_F, r + 23, 0, 0);
    drive('{0}, '{7}, 1'b0, 35);

    // No ack at all: four attempts, then sticky fail.
    r = cyc + 1;
    expect_ev(EV_BUSY_R, r, 0, 0);
    for (int i = 0; i < 4; i++) begin
      expect_ev(EV_RST_R, r + 68 * i, 0, i);
      expect_ev(EV_RST_F, r + 68 * i + 4, 0, i);
    end
    expect_ev(EV_FAIL_R, r + 272, 1, 3);
    expect_ev(EV_BUSY_F, r + 288, 1, 3);
    drive('{0}, '{-1}, 1'b0, 300);
    chk("fail_sticky_idle", int'(bus.fail), 1);
    chk("retry_after_fail", int'(bus.retry_cnt), 3);

    // Ack in the very last timeout cycle still counts as success.
    r = cyc + 1;
    expect_ev(EV_BUSY_R, r, 0, 0);
    expect_ev(EV_FAIL_F, r, 0, 0);
    expect_ev(EV_RST_R,  r, 0, 0);
    expect_ev(EV_RST_F,  r + 4, 0, 0);
    expect_ev(EV_DONE_R, r + 68, 0, 0);
    expect_ev(EV_DONE_F, r + 69, 0, 0);
    expect_ev(EV_BUSY_F, r + 84, 0, 0);
    drive('{0}, '{68}, 1'b0, 100);

    // Three extra requests while busy merge into one back-to-back sequence.
    r = cyc + 1;
    expect_ev(EV_BUSY_R, r, 0, 0);
    expect_ev(EV_RST_R,  r, 0, 0);
    expect_ev(EV_RST_F,  r + 4, 0, 0);
    expect_ev(EV_DONE_R, r + 7, 0, 0);
    expect_ev(EV_DONE_F, r + 8, 0, 0);
    expect_ev(EV_RST_R,  r + 23, 0, 0);
    expect_ev(EV_RST_F,  r + 27, 0, 0);
    expect_ev(EV_DONE_R, r + 30, 0, 0);
    expect_ev(EV_DONE_F, r + 31, 0, 0);
    expect_ev(EV_BUSY_F, r + 46, 0, 0);
    drive('{0, 2, 6, 11}, '{7, 30}, 1'b0, 60);

    // ack held high throughout: ignored in ASSERT, success on first WAIT_ACK cycle.
    r = cyc + 4;
    expect_ev(EV_BUSY_R, r, 0, 0);
    expect_ev(EV_RST_R,  r, 0, 0);
    expect_ev(EV_RST_F,  r + 4, 0, 0);
    expect_ev(EV_DONE_R, r + 5, 0, 0);
    expect_ev(EV_DONE_F, r + 6, 0, 0);
    expect_ev(EV_BUSY_F, r + 21, 0, 0);
    drive('{3}, '{-1}, 1'b1, 35);

    // Async reset in the second ASSERT cycle, with a pending request queued.
    r = cyc + 1;
    expect_ev(EV_BUSY_R, r, 0, 0);
    expect_ev(EV_RST_R,  r, 0, 0);
    expect_ev(EV_RST_F,  r + 2, 0, 0);
    expect_ev(EV_BUSY_F, r + 2, 0, 0);
    drive('{0, 1}, '{-1}, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", int'(bus.rst_out), 0);
    chk("async_busy",    int'(bus.busy), 0);
    chk("async_done",    int'(bus.done), 0);
    chk("async_fail",    int'(bus.fail), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive('{-1}, '{-1}, 1'b0, 30);
    chk("post_reset_busy",  int'(bus.busy), 0);
    chk("post_reset_fail",  int'(bus.fail), 0);
    chk("post_reset_retry", int'(bus.retry_cnt), 0);

    repeat (5) @(negedge clk);
    chk("events_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reset_pulse_sequencer.md
RESET_PULSE_SEQUENCER -- requirements
Module: reset_pulse_sequencer

Interface
REQ-001 Parameter PULSE_LEN, default 4: cycles rst_out is held high per attempt, ≥1.
REQ-002 Parameter ACK_TIMEOUT, default 64: cycles spent waiting for ack per attempt, ≥1.
REQ-003 Parameter MAX_RETRY, default 3: re-attempts allowed after the first timeout, ≥0.
REQ-004 Parameter HOLDOFF, default 16: quiet cycles after a sequence ends, ≥1.
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset: assertion asynchronous, release sampled on clk.
REQ-007 req  input  1  reset request, sampled each cycle, level or pulse.
REQ-008 ack  input  1  far-end reset acknowledge, already synchronous to clk.
REQ-009 rst_out  output  1  reset pulse toward the crossing FIFO write side, registered.
REQ-010 busy  output  1  sequence in progress (any state other than IDLE), registered.
REQ-011 done  output  1  single-cycle success strobe, registered.
REQ-012 fail  output  1  sticky failure flag, registered.
REQ-013 retry_cnt  output  $clog2(MAX_RETRY+1)  retries used in the current or last sequence.

Function
REQ-014 States SHALL be IDLE, ASSERT, WAIT_ACK and HOLDOFF, held in one registered state variable.
REQ-015 IDLE: if req or pending is sampled high at edge k, the FSM SHALL enter ASSERT; rst_out=1 and busy=1 from edge k+1.
REQ-016 IDLE entry into ASSERT SHALL clear pending, retry_cnt and fail.
REQ-017 ASSERT: rst_out SHALL stay high exactly PULSE_LEN cycles, then the FSM enters WAIT_ACK with rst_out=0.
REQ-018 WAIT_ACK: ack sampled high SHALL cause entry to HOLDOFF, with done=1 for exactly the next cycle.
REQ-019 WAIT_ACK timeout: ACK_TIMEOUT cycles without ack SHALL, if retry_cnt<MAX_RETRY, increment retry_cnt and re-enter ASSERT.
REQ-020 WAIT_ACK timeout with retry_cnt==MAX_RETRY SHALL set fail=1 and enter HOLDOFF; done stays 0.
REQ-021 Ack sampled in the final timeout cycle SHALL count as success: no retry, no fail.
REQ-022 ack SHALL be ignored in IDLE, ASSERT and HOLDOFF.
REQ-023 HOLDOFF: the FSM SHALL stay HOLDOFF cycles with rst_out=0 and busy=1.
REQ-024 HOLDOFF expiry: with pending=1 the FSM SHALL enter ASSERT directly (busy never drops); otherwise it enters IDLE with busy=0.
REQ-025 req sampled high in any non-IDLE state SHALL set a one-deep pending flag; further requests SHALL merge into it.
REQ-026 A pending request SHALL reset retry_cnt to 0 on its ASSERT entry; fail SHALL remain readable until that entry.
REQ-027 Counters SHALL be sized $clog2(max value+1) and SHALL saturate rather than wrap.
REQ-028 No combinational path SHALL exist from req or ack to any output.

Reset
REQ-029 rst_n low SHALL immediately force: state=IDLE, rst_out=0, busy=0, done=0, fail=0, retry_cnt=0, pending=0, all counters=0.
REQ-030 rst_n assertion mid-sequence SHALL abort the sequence with no done and no fail.
REQ-031 After release, the first req SHALL be honoured no earlier than the first rising edge with rst_n high.

Verification
REQ-032 Single req pulse at edge 0, ack high at edge 7 -> rst_out high edges 1-4; done high edge 8 only; busy low from edge 24; fail=0, retry_cnt=0.
REQ-033 req pulse, ack never asserted -> 4 rst_out pulses of 4 cycles each, each separated by 64 low cycles; then fail=1, retry_cnt=3, done never high; busy drops 16 cycles after the last timeout.
REQ-034 Ack during the first timeout's final WAIT_ACK cycle -> done pulses, retry_cnt=0, no second rst_out pulse.
REQ-035 Second req during HOLDOFF -> busy stays high continuously; a new 4-cycle rst_out pulse starts the cycle after HOLDOFF expiry; three reqs during busy yield only one extra sequence.
REQ-036 rst_n driven low at cycle 2 of ASSERT -> rst_out=0 without waiting for a clk edge; after release: no pending, no done, fail=0.
REQ-037 ack held high continuously from idle, then req -> ack ignored during ASSERT; success declared on the first WAIT_ACK cycle (done one cycle later).
